// File: rtl/mult_pkg.sv
// Shared definitions for the add-shift multiplier control sequencer.
//   mult_state_t : sequencer states (IDLE, CLR, ARITH, SHIFT, HOLD)
//   MULT_N       : default operand width, which is also the iteration count
//   MULT_CNT_W   : width of the iteration counter
package mult_pkg;

    localparam int MULT_N     = 8;
    localparam int MULT_CNT_W = $clog2(MULT_N);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ARITH = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } mult_state_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier sequencer.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   clr        : force cnt to 0 on the next edge
//   inc        : request an advance (SHIFT phase)
//   en         : qualifies inc (single-step pulse, or 1)
//   cnt        : current iteration index, 0 .. N-1
//   last       : high when cnt == N-1
// The counter wraps from N-1 back to 0, so it is already 0 when the
// sequencer reaches HOLD.
module mult_iter_counter
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          inc,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          last
);

    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && en) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for the 8-bit add-shift multiplier datapath.
// Steps the datapath through one clear cycle, N add/shift iterations (the
// last add is a subtract-correction) and then holds until run is released.
// Optional feature: define SEQ_STEP_EN to add the step port; ARITH/SHIFT
// then advance (and fire ld_xa / shift_en) only on cycles with step = 1.
// Ports:
//   clk, reset : system clock, synchronous active-high reset (controller only)
//   run        : level execute request (debounced)
//   clra_ldb   : level request to clear X/A and load B (honoured in IDLE only)
//   m          : B[0], current multiplier bit
//   step       : single-step advance (SEQ_STEP_EN only)
//   clr_xa     : clear X and A
//   ld_b       : load B from switches
//   ld_xa      : load adder result into X and A
//   sub_sel    : adder computes A - S
//   shift_en   : arithmetic right shift of X:A:B
//   busy       : operation in progress (CLR, ARITH, SHIFT)
//   done       : result valid, waiting for run to drop
//   state, cnt : debug view of the FSM state and iteration counter
// Handshake: there is no valid/ready pair here; run is a level request that
// starts exactly one operation per IDLE visit, and done stays high until run
// is observed low in HOLD.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int N  = MULT_N,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          clra_ldb,
    input  logic          m,
`ifdef SEQ_STEP_EN
    input  logic          step,
`endif
    output logic          clr_xa,
    output logic          ld_b,
    output logic          ld_xa,
    output logic          sub_sel,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output mult_state_t   state,
    output logic [CW-1:0] cnt
);

    mult_state_t state_next;
    logic        advance;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        last;

`ifdef SEQ_STEP_EN
    assign advance = step;
`else
    assign advance = 1'b1;
`endif

    mult_iter_counter #(
        .N  (N),
        .CW (CW)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .en    (advance),
        .cnt   (cnt),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        clr_xa     = 1'b0;
        ld_b       = 1'b0;
        ld_xa      = 1'b0;
        sub_sel    = 1'b0;
        shift_en   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;

        case (state)
            IDLE: begin
                // run has priority; a simultaneous clra_ldb is dropped.
                if (run) begin
                    state_next = CLR;
                end else if (clra_ldb) begin
                    clr_xa = 1'b1;
                    ld_b   = 1'b1;
                end
            end
            CLR: begin
                busy       = 1'b1;
                clr_xa     = 1'b1;
                cnt_clr    = 1'b1;
                state_next = ARITH;
            end
            ARITH: begin
                busy  = 1'b1;
                ld_xa = m && advance;
                // The last partial product carries the sign weight, so it
                // is subtracted. sub_sel is forced low whenever no load.
                sub_sel = ld_xa && last;
                if (advance) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = advance;
                cnt_inc  = 1'b1;
                if (advance) begin
                    state_next = last ? HOLD : ARITH;
                end
            end
            HOLD: begin
                done = 1'b1;
                if (!run) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
